drp_responder: RTL and testbench

// - DRP slave (responder) emulating the XADC register interface: 128 x 16-bit address space, status regs 0x00-0x3F, control regs 0x40-0x7F.
// - Lets DRP initiator logic (eoc-driven readers, config writers) be built and simulated without the XADC hard block.
// - Sample port loads status registers; eoc/channel outputs mimic XADC sequencer pulses.

---
 rtl/drp_pkg.sv | 14 +
 rtl/drp_minmax_tracker.sv | 43 ++++
 rtl/drp_responder.sv | 128 ++++++++++++
 tb/tb_drp_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/drp_pkg.sv
// rtl/drp_pkg.sv - widths, address map and FSM states shared by the DRP responder
package drp_pkg;
   localparam int DRP_AW    = 7;
   localparam int DRP_DW    = 16;
   localparam int MINMAX_CH = 3;

   localparam logic [DRP_AW-1:0] ADDR_CTRL_BASE = 7'h40;
   localparam logic [DRP_AW-1:0] ADDR_MAX_BASE  = 7'h20;
   localparam logic [DRP_AW-1:0] ADDR_MIN_BASE  = 7'h24;

   localparam logic [DRP_DW-1:0] MIN_RESET = 16'hFFF0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} drp_state_e;
endpackage

// File: rtl/drp_minmax_tracker.sv
// rtl/drp_minmax_tracker.sv - running max/min of the stored 16-bit sample for channels 0..2
module drp_minmax_tracker
   import drp_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              sample_valid_i,
   input  logic [4:0]                        sample_chan_i,
   input  logic [DRP_DW-1:0]                 value_i,
   output logic [MINMAX_CH-1:0][DRP_DW-1:0]  max_o,
   output logic [MINMAX_CH-1:0][DRP_DW-1:0]  min_o
);

   logic [MINMAX_CH-1:0][DRP_DW-1:0] max_q, max_d;
   logic [MINMAX_CH-1:0][DRP_DW-1:0] min_q, min_d;

   always_comb begin
      max_d = max_q;
      min_d = min_q;
      for (int i = 0; i < MINMAX_CH; i++) begin
         if (sample_valid_i && sample_chan_i == 5'(i)) begin
            if (value_i > max_q[i]) max_d[i] = value_i;
            if (value_i < min_q[i]) min_d[i] = value_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MINMAX_CH; i++) begin
            max_q[i] <= '0;
            min_q[i] <= MIN_RESET;
         end
      end else begin
         max_q <= max_d;
         min_q <= min_d;
      end
   end

   assign max_o = max_q;
   assign min_o = min_q;

endmodule

// File: rtl/drp_responder.sv
// rtl/drp_responder.sv - XADC-style DRP register responder; DRP_MINMAX_EN adds min/max tracking at 0x20-0x26
module drp_responder
   import drp_pkg::*;
#(
   parameter int unsigned DRDY_LAT = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              den,
   input  logic              dwe,
   input  logic [DRP_AW-1:0] daddr,
   input  logic [DRP_DW-1:0] di,
   output logic              drdy,
   output logic [DRP_DW-1:0] do_data,
   output logic              busy,
   output logic              err,
   input  logic              sample_valid,
   input  logic [4:0]        sample_chan,
   input  logic [11:0]       sample_data,
   output logic              eoc_out,
   output logic [4:0]        channel_out
);

   localparam logic [3:0] LAT_M1 = 4'(DRDY_LAT - 1);

   // Only the reachable parts of the map are stored: samples at 0x00-0x1F, control at 0x40-0x7F.
   logic [DRP_DW-1:0] status_q [32];
   logic [DRP_DW-1:0] ctrl_q   [64];

   drp_state_e        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DRP_AW-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DRP_DW-1:0] wdata_q, wdata_d;
   logic              err_q, eoc_q;
   logic [4:0]        chan_q;
   logic [DRP_DW-1:0] rd_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: if (den) begin
            addr_d  = daddr;
            we_d    = dwe;
            wdata_d = di;
            cnt_d   = LAT_M1;
            state_d = (LAT_M1 == 4'd0) ? RESP : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef DRP_MINMAX_EN
   logic [MINMAX_CH-1:0][DRP_DW-1:0] max_w, min_w;

   drp_minmax_tracker u_minmax (
      .clk            (clk),
      .rst            (rst),
      .sample_valid_i (sample_valid),
      .sample_chan_i  (sample_chan),
      .value_i        ({sample_data, 4'h0}),
      .max_o          (max_w),
      .min_o          (min_w)
   );
`endif

   always_comb begin
      rd_data = '0;
      if (addr_q >= ADDR_CTRL_BASE) begin
         rd_data = ctrl_q[addr_q[5:0]];
      end else if (addr_q < ADDR_MAX_BASE) begin
         rd_data = status_q[addr_q[4:0]];
      end
`ifdef DRP_MINMAX_EN
      for (int i = 0; i < MINMAX_CH; i++) begin
         if (addr_q == ADDR_MAX_BASE + 7'(i)) rd_data = max_w[i];
         if (addr_q == ADDR_MIN_BASE + 7'(i)) rd_data = min_w[i];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         eoc_q   <= 1'b0;
         chan_q  <= '0;
         for (int i = 0; i < 32; i++) status_q[i] <= '0;
         for (int i = 0; i < 64; i++) ctrl_q[i]   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         err_q   <= den && (state_q != IDLE);
         eoc_q   <= sample_valid;
         if (sample_valid) begin
            chan_q                <= sample_chan;
            status_q[sample_chan] <= {sample_data, 4'h0};
         end
         // Writes commit at the end of RESP, so a read in RESP never sees them.
         if (state_q == RESP && we_q && addr_q >= ADDR_CTRL_BASE)
            ctrl_q[addr_q[5:0]] <= wdata_q;
      end
   end

   assign drdy        = (state_q == RESP);
   assign do_data     = (state_q == RESP && !we_q) ? rd_data : '0;
   assign busy        = (state_q != IDLE);
   assign err         = err_q;
   assign eoc_out     = eoc_q;
   assign channel_out = chan_q;

endmodule

// File: tb/tb_drp_responder.sv
// tb/tb_drp_responder.sv - random and directed bench for drp_responder against a cycle-stamped transaction model
module tb_drp_responder;
   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        den = 1'b0, dwe = 1'b0;
   logic [6:0]  daddr = '0;
   logic [15:0] di = '0;
   logic        drdy, busy, err, eoc_out;
   logic [15:0] do_data;
   logic        sample_valid = 1'b0;
   logic [4:0]  sample_chan = '0, channel_out;
   logic [11:0] sample_data = '0;

   int errors = 0;
   int checks = 0;

   drp_responder #(.DRDY_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .den(den), .dwe(dwe), .daddr(daddr), .di(di),
      .drdy(drdy), .do_data(do_data), .busy(busy), .err(err),
      .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
      .eoc_out(eoc_out), .channel_out(channel_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the register map as a plain array plus at most one pending transaction
   // stamped with the cycle its drdy is due.
   logic [15:0] m_regs [128];
   logic [15:0] m_max [3];
   logic [15:0] m_min [3];
   bit          m_ok = 0, m_pend, m_we, m_err, m_eoc;
   int          m_cyc, m_done;
   logic [6:0]  m_addr;
   logic [15:0] m_wdata;
   logic [4:0]  m_chan;

   function automatic logic [15:0] m_read(input logic [6:0] a);
`ifdef DRP_MINMAX_EN
      if (a >= 7'h20 && a <= 7'h22) return m_max[a - 7'h20];
      if (a >= 7'h24 && a <= 7'h26) return m_min[a - 7'h24];
`endif
      return m_regs[a];
   endfunction

   always @(posedge clk) begin
      bit          busy_c, e_drdy;
      logic [15:0] v;
      if (rst) begin
         for (int i = 0; i < 128; i++) m_regs[i] = '0;
         for (int i = 0; i < 3; i++) begin m_max[i] = 16'h0000; m_min[i] = 16'hFFF0; end
         m_pend = 0; m_err = 0; m_eoc = 0; m_chan = '0; m_cyc = 0; m_ok = 1;
      end else if (m_ok) begin
         busy_c = m_pend;
         m_err  = den && busy_c;
         if (m_pend && m_done == m_cyc) begin
            if (m_we && m_addr >= 7'h40) m_regs[m_addr] = m_wdata;
            m_pend = 0;
         end
         if (den && !busy_c) begin
            m_pend = 1; m_done = m_cyc + LAT;
            m_addr = daddr; m_we = dwe; m_wdata = di;
         end
         m_eoc = sample_valid;
         if (sample_valid) begin
            v = {sample_data, 4'h0};
            m_regs[{2'b00, sample_chan}] = v;
            m_chan = sample_chan;
            if (sample_chan < 3) begin
               if (v > m_max[sample_chan]) m_max[sample_chan] = v;
               if (v < m_min[sample_chan]) m_min[sample_chan] = v;
            end
         end
         m_cyc++;
      end
      if (m_ok) begin
         #1;
         e_drdy = m_pend && (m_done == m_cyc);
         chk("drdy", drdy, e_drdy);
         chk("do_data", do_data, (e_drdy && !m_we) ? m_read(m_addr) : 16'h0);
         chk("busy", busy, m_pend);
         chk("err", err, m_err);
         chk("eoc_out", eoc_out, m_eoc);
         chk("channel_out", channel_out, m_chan);
      end
   end

   task automatic drp_txn(input logic we, input logic [6:0] a, input logic [15:0] d,
                          output logic [15:0] rdata, output int lat);
      @(negedge clk); den = 1'b1; dwe = we; daddr = a; di = d;
      @(negedge clk); den = 1'b0; dwe = 1'b0;
      lat = 1;
      while (!drdy && lat < 40) begin @(negedge clk); lat++; end
      rdata = do_data;
      if (!drdy) chk("drdy_timeout", 32'(lat), 32'(LAT));
   endtask

   task automatic drp_read(input string name, input logic [6:0] a, input logic [15:0] exp);
      logic [15:0] r; int lat;
      drp_txn(1'b0, a, 16'h0, r, lat);
      chk(name, r, exp);
   endtask

   task automatic drp_write(input logic [6:0] a, input logic [15:0] d);
      logic [15:0] r; int lat;
      drp_txn(1'b1, a, d, r, lat);
      chk("write_do_zero", r, 16'h0);
   endtask

   task automatic do_sample(input logic [4:0] ch, input logic [11:0] d);
      @(negedge clk); sample_valid = 1'b1; sample_chan = ch; sample_data = d;
      @(negedge clk); sample_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] r;
      int lat, nbusy, nerr, ndrdy, drdy_at;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_drdy", drdy, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_do", do_data, 16'h0);
      chk("reset_chan", channel_out, 5'h0);

      // Read after reset: latency and busy width
      @(negedge clk); den = 1'b1; dwe = 1'b0; daddr = 7'h40;
      @(negedge clk); den = 1'b0;
      lat = 1; nbusy = 0;
      while (!drdy && lat < 40) begin nbusy += int'(busy); @(negedge clk); lat++; end
      nbusy += int'(busy);
      chk("read40_latency", 32'(lat), 32'd4);
      chk("read40_data", do_data, 16'h0000);
      chk("read40_busy_cycles", 32'(nbusy), 32'd4);

      drp_write(7'h41, 16'hA5A5);
      drp_read("read41", 7'h41, 16'hA5A5);

      @(negedge clk); sample_valid = 1'b1; sample_chan = 5'h15; sample_data = 12'h333;
      @(negedge clk); sample_valid = 1'b0;
      chk("sample_eoc", eoc_out, 1'b1);
      chk("sample_chan", channel_out, 5'h15);
      @(negedge clk);
      chk("sample_eoc_oneshot", eoc_out, 1'b0);
      drp_read("read15", 7'h15, 16'h3330);

      drp_write(7'h03, 16'hFFFF);
      drp_read("read03_ignored", 7'h03, 16'h0000);

      // Second den two cycles into a transaction is dropped with an err pulse
      @(negedge clk); den = 1'b1; dwe = 1'b0; daddr = 7'h41;
      nerr = 0; ndrdy = 0; drdy_at = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         den = (k == 2);
         daddr = 7'h15;
         nerr += int'(err);
         if (drdy) begin ndrdy++; drdy_at = k; r = do_data; end
      end
      den = 1'b0;
      chk("overlap_err_pulses", 32'(nerr), 32'd1);
      chk("overlap_drdy_count", 32'(ndrdy), 32'd1);
      chk("overlap_drdy_cycle", 32'(drdy_at), 32'd4);
      chk("overlap_data", r, 16'hA5A5);

      do_sample(5'h00, 12'h100);
      do_sample(5'h00, 12'h800);
      do_sample(5'h00, 12'h050);
`ifdef DRP_MINMAX_EN
      drp_read("minmax_max0", 7'h20, 16'h8000);
      drp_read("minmax_min0", 7'h24, 16'h0500);
`else
      drp_read("minmax_off_20", 7'h20, 16'h0000);
      drp_read("minmax_off_24", 7'h24, 16'h0000);
`endif

      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         den          = ($urandom_range(0, 3) == 0);
         dwe          = $urandom_range(0, 1);
         daddr        = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 63));
         di           = 16'($urandom);
         sample_valid = ($urandom_range(0, 2) == 0);
         sample_chan  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom_range(0, 31));
         sample_data  = 12'($urandom);
      end
      @(negedge clk); den = 1'b0; sample_valid = 1'b0;
      repeat (LAT + 2) @(negedge clk);

      // Reset while a transaction is in WAIT
      drp_write(7'h41, 16'h1234);
      @(negedge clk); den = 1'b1; dwe = 1'b0; daddr = 7'h41;
      @(negedge clk); den = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("rst_busy_after", busy, 1'b0);
      ndrdy = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); ndrdy += int'(drdy); end
      chk("rst_no_drdy", 32'(ndrdy), 32'd0);
      drp_read("rst_read41", 7'h41, 16'h0000);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
